// File: rtl/pc_fetch_control_pkg.sv
// pc_fetch_control_pkg: shared reset PC default, alignment mask and next-PC select encoding
package pc_fetch_control_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0] ALIGN_MASK = 2'b00;
  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JMP  = 2'd2,
    SEL_PEND = 2'd3
  } sel_e;
endpackage

// File: rtl/pc_redirect_buffer.sv
// pc_redirect_buffer: holds one redirect raised during a stall; in Clk/Reset/Stall/branch/jump, out pending flag, target, is-branch
module pc_redirect_buffer
  import pc_fetch_control_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] BranchTarget,
  input  logic                Jump,
  input  logic [PC_WIDTH-1:0] JumpTarget,
  output logic                pending,
  output logic [PC_WIDTH-1:0] pend_target,
  output logic                pend_is_branch
);
  always_ff @(posedge Clk) begin
    if (Reset || !Stall) begin
      pending        <= 1'b0;
      pend_target    <= '0;
      pend_is_branch <= 1'b0;
    end else if (BranchTaken) begin
      pending        <= 1'b1;
      pend_target    <= BranchTarget;
      pend_is_branch <= 1'b1;
    end else if (Jump && !(pending && pend_is_branch)) begin
      pending        <= 1'b1;
      pend_target    <= JumpTarget;
      pend_is_branch <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_fetch_control.sv
// pc_fetch_control: IF-stage PC register and next-PC select; in stall/PC+4/branch/jump, out PCResult, RedirectPending, FlushIF, MisalignFault, FetchCount
module pc_fetch_control
  import pc_fetch_control_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_WIDTH = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic [PC_WIDTH-1:0] PCAddResult,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] BranchTarget,
  input  logic                Jump,
  input  logic [PC_WIDTH-1:0] JumpTarget,
  output logic [PC_WIDTH-1:0] PCResult,
  output logic                RedirectPending,
  output logic                FlushIF,
  output logic                MisalignFault,
  output logic [31:0]         FetchCount
);
  logic [PC_WIDTH-1:0] pend_target, target;
  logic                pend_is_branch, redirect;
  sel_e                sel;
  pc_redirect_buffer #(.PC_WIDTH(PC_WIDTH)) u_buf (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .pending(RedirectPending), .pend_target(pend_target), .pend_is_branch(pend_is_branch)
  );
  always_comb begin
    sel = BranchTaken ? SEL_BR : Jump ? SEL_JMP : RedirectPending ? SEL_PEND : SEL_SEQ;
    target = (sel == SEL_BR) ? BranchTarget : (sel == SEL_JMP) ? JumpTarget : pend_target;
    redirect = !Stall && (sel != SEL_SEQ);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCResult      <= PC_WIDTH'(RESET_PC);
      FlushIF       <= 1'b0;
      MisalignFault <= 1'b0;
      FetchCount    <= '0;
    end else begin
      FlushIF <= redirect;
      if (!Stall) begin
        PCResult   <= redirect ? {target[PC_WIDTH-1:2], ALIGN_MASK} : PCAddResult;
        FetchCount <= FetchCount + 32'd1;
      end
      if (redirect && target[1:0] != 2'b00) MisalignFault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_fetch_control.sv
// tb_pc_fetch_control: directed-vector bench for pc_fetch_control
module tb_pc_fetch_control;
  logic        Clk = 0, Reset = 0, Stall = 0, BranchTaken = 0, Jump = 0;
  logic [31:0] PCAddResult = 0, BranchTarget = 0, JumpTarget = 0;
  logic [31:0] PCResult, FetchCount;
  logic        RedirectPending, FlushIF, MisalignFault;
  int vecs = 0, errs = 0;

  pc_fetch_control #(.RESET_PC(32'h0040_0000), .PC_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCAddResult(PCAddResult),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .PCResult(PCResult), .RedirectPending(RedirectPending), .FlushIF(FlushIF),
    .MisalignFault(MisalignFault), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1;
    step();
    step();
    vecs++; if (PCResult !== 32'h0040_0000) begin errs++; $display("FAIL reset_pc got %h want %h", PCResult, 32'h0040_0000); end
    vecs++; if ({RedirectPending, FlushIF, MisalignFault} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {RedirectPending, FlushIF, MisalignFault}); end
    vecs++; if (FetchCount !== 32'd0) begin errs++; $display("FAIL reset_count got %0d want 0", FetchCount); end
    Reset = 0;
    PCAddResult = 32'h0040_0004;
    step();
    vecs++; if (PCResult !== 32'h0040_0004) begin errs++; $display("FAIL seq1_pc got %h want %h", PCResult, 32'h0040_0004); end
    PCAddResult = 32'h0040_0008;
    step();
    vecs++; if (PCResult !== 32'h0040_0008) begin errs++; $display("FAIL seq2_pc got %h want %h", PCResult, 32'h0040_0008); end
    vecs++; if (FetchCount !== 32'd2) begin errs++; $display("FAIL seq2_count got %0d want 2", FetchCount); end
  endtask

  task automatic test_branch_jump_priority();
    PCAddResult = 32'h0040_000C;
    BranchTaken = 1; BranchTarget = 32'h100;
    Jump = 1; JumpTarget = 32'h200;
    step();
    BranchTaken = 0; Jump = 0;
    vecs++; if (PCResult !== 32'h100) begin errs++; $display("FAIL prio_pc got %h want %h", PCResult, 32'h100); end
    vecs++; if (FlushIF !== 1'b1) begin errs++; $display("FAIL prio_flush got %b want 1", FlushIF); end
    PCAddResult = 32'h104;
    step();
    vecs++; if (PCResult !== 32'h104) begin errs++; $display("FAIL prio_seq_pc got %h want %h", PCResult, 32'h104); end
    vecs++; if (FlushIF !== 1'b0) begin errs++; $display("FAIL prio_flush_drop got %b want 0", FlushIF); end
    vecs++; if (FetchCount !== 32'd4) begin errs++; $display("FAIL prio_count got %0d want 4", FetchCount); end
  endtask

  task automatic test_stall_overwrite();
    PCAddResult = 32'h108;
    Stall = 1; Jump = 1; JumpTarget = 32'h300;
    step();
    vecs++; if (RedirectPending !== 1'b1) begin errs++; $display("FAIL stall_jmp_pending got %b want 1", RedirectPending); end
    vecs++; if (PCResult !== 32'h104) begin errs++; $display("FAIL stall_hold_pc got %h want %h", PCResult, 32'h104); end
    Jump = 0; BranchTaken = 1; BranchTarget = 32'h400;
    step();
    BranchTaken = 0;
    vecs++; if (FlushIF !== 1'b0) begin errs++; $display("FAIL stall_flush got %b want 0", FlushIF); end
    step();
    vecs++; if (RedirectPending !== 1'b1 || PCResult !== 32'h104) begin errs++; $display("FAIL stall3 got pend=%b pc=%h want pend=1 pc=%h", RedirectPending, PCResult, 32'h104); end
    vecs++; if (FetchCount !== 32'd4) begin errs++; $display("FAIL stall_count_hold got %0d want 4", FetchCount); end
    Stall = 0;
    step();
    vecs++; if (PCResult !== 32'h400) begin errs++; $display("FAIL release_pc got %h want %h", PCResult, 32'h400); end
    vecs++; if (FlushIF !== 1'b1 || RedirectPending !== 1'b0) begin errs++; $display("FAIL release_flags got flush=%b pend=%b want flush=1 pend=0", FlushIF, RedirectPending); end
    vecs++; if (FetchCount !== 32'd5) begin errs++; $display("FAIL release_count got %0d want 5", FetchCount); end
    PCAddResult = 32'h404;
    step();
    vecs++; if (PCResult !== 32'h404 || FlushIF !== 1'b0) begin errs++; $display("FAIL post_release got pc=%h flush=%b want pc=%h flush=0", PCResult, FlushIF, 32'h404); end
  endtask

  task automatic test_branch_blocks_jump();
    PCAddResult = 32'h408;
    Stall = 1; BranchTaken = 1; BranchTarget = 32'h500;
    step();
    BranchTaken = 0; Jump = 1; JumpTarget = 32'h600;
    step();
    Jump = 0; Stall = 0;
    step();
    vecs++; if (PCResult !== 32'h500) begin errs++; $display("FAIL br_blocks_jmp got %h want %h", PCResult, 32'h500); end
    vecs++; if (FetchCount !== 32'd7) begin errs++; $display("FAIL br_blocks_count got %0d want 7", FetchCount); end
  endtask

  task automatic test_jump_overwrite();
    PCAddResult = 32'h504;
    Stall = 1; Jump = 1; JumpTarget = 32'h700;
    step();
    JumpTarget = 32'h704;
    step();
    Jump = 0; Stall = 0;
    step();
    vecs++; if (PCResult !== 32'h704) begin errs++; $display("FAIL jmp_overwrite got %h want %h", PCResult, 32'h704); end
    vecs++; if (MisalignFault !== 1'b0) begin errs++; $display("FAIL misalign_early got %b want 0", MisalignFault); end
  endtask

  task automatic test_misalign();
    PCAddResult = 32'h708;
    Jump = 1; JumpTarget = 32'h0000_0207;
    step();
    Jump = 0;
    vecs++; if (PCResult !== 32'h0000_0204) begin errs++; $display("FAIL misalign_pc got %h want %h", PCResult, 32'h204); end
    vecs++; if (MisalignFault !== 1'b1) begin errs++; $display("FAIL misalign_set got %b want 1", MisalignFault); end
    BranchTaken = 1; BranchTarget = 32'h800;
    step();
    BranchTaken = 0;
    vecs++; if (PCResult !== 32'h800 || MisalignFault !== 1'b1) begin errs++; $display("FAIL misalign_sticky got pc=%h mf=%b want pc=%h mf=1", PCResult, MisalignFault, 32'h800); end
    vecs++; if (FetchCount !== 32'd10) begin errs++; $display("FAIL misalign_count got %0d want 10", FetchCount); end
  endtask

  task automatic test_reset_pending();
    PCAddResult = 32'h804;
    Stall = 1; BranchTaken = 1; BranchTarget = 32'h900;
    step();
    BranchTaken = 0;
    vecs++; if (RedirectPending !== 1'b1) begin errs++; $display("FAIL pre_reset_pending got %b want 1", RedirectPending); end
    Reset = 1;
    step();
    vecs++; if (PCResult !== 32'h0040_0000 || RedirectPending !== 1'b0) begin errs++; $display("FAIL midstall_reset got pc=%h pend=%b want pc=%h pend=0", PCResult, RedirectPending, 32'h0040_0000); end
    vecs++; if (MisalignFault !== 1'b0 || FetchCount !== 32'd0) begin errs++; $display("FAIL midstall_reset_state got mf=%b cnt=%0d want mf=0 cnt=0", MisalignFault, FetchCount); end
    Reset = 0; Stall = 0; PCAddResult = 32'h0040_0004;
    step();
    vecs++; if (PCResult !== 32'h0040_0004 || FlushIF !== 1'b0) begin errs++; $display("FAIL no_stale got pc=%h flush=%b want pc=%h flush=0", PCResult, FlushIF, 32'h0040_0004); end
    vecs++; if (FetchCount !== 32'd1) begin errs++; $display("FAIL no_stale_count got %0d want 1", FetchCount); end
  endtask

  initial begin
    test_reset();
    test_branch_jump_priority();
    test_stall_overwrite();
    test_branch_blocks_jump();
    test_jump_overwrite();
    test_misalign();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
